// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch stage and the next-PC unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_DRAIN = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  localparam logic [1:0] INST_ALIGN_MASK = 2'b11;

  // Control-transfer kinds produced by the execute-stage next-PC unit.
  localparam logic [1:0] S_BR   = 2'd0;
  localparam logic [1:0] S_JAL  = 2'd1;
  localparam logic [1:0] S_JALR = 2'd2;

endpackage

// File: rtl/fetch_buf.sv
// One-entry instruction/PC holding register toward decode.
module fetch_buf #(
  parameter int DATA_WIDTH = 64,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  input  logic                  load_i,
  input  logic [INST_WIDTH-1:0] load_inst_i,
  input  logic [DATA_WIDTH-1:0] load_pc_i,
  input  logic                  pop_i,
  input  logic                  flush_i,
  output logic                  valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] pc_o
);

  logic                  r_valid;
  logic [INST_WIDTH-1:0] r_inst;
  logic [DATA_WIDTH-1:0] r_pc;

  // Flush beats load beats pop; a same-cycle pop and load leaves the entry valid.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_inst  <= '0;
      r_pc    <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
    end else if (load_i) begin
      r_valid <= 1'b1;
      r_inst  <= load_inst_i;
      r_pc    <= load_pc_i;
    end else if (pop_i) begin
      r_valid <= 1'b0;
    end
  end

  assign valid_o = r_valid;
  assign inst_o  = r_inst;
  assign pc_o    = r_pc;

endmodule

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: one outstanding imem request, redirect squash, misalign fault.
//   state   | meaning
//   S_REQ   | ready to issue a request at r_pc
//   S_WAIT  | request accepted, waiting for its response
//   S_DRAIN | redirected while waiting; next response is discarded
//   S_FAULT | misaligned redirect seen; frozen until reset
module fetch_pc_ctrl
  import fetch_pkg::*;
#(
  parameter int                    DATA_WIDTH = 64,
  parameter int                    INST_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = 64'h8000_0000
) (
  input  logic                  clk_i,
  input  logic                  rst_n_i,
  output logic                  req_valid_o,
  output logic [DATA_WIDTH-1:0] req_addr_o,
  input  logic                  req_ready_i,
  input  logic                  rsp_valid_i,
  input  logic [INST_WIDTH-1:0] rsp_data_i,
  output logic                  inst_valid_o,
  output logic [INST_WIDTH-1:0] inst_o,
  output logic [DATA_WIDTH-1:0] inst_pc_o,
  input  logic                  inst_ready_i,
  input  logic                  redir_valid_i,
  input  logic [DATA_WIDTH-1:0] redir_pc_i,
  output logic                  fault_o,
  output logic [DATA_WIDTH-1:0] fault_pc_o,
  output logic [31:0]           redir_cnt_o
);

  localparam logic [DATA_WIDTH-1:0] PC_STEP = DATA_WIDTH'(4);

  fetch_state_e          r_state, w_state_nxt;
  logic [DATA_WIDTH-1:0] r_pc, r_infl_pc, r_fault_pc;
  logic                  r_fault;
  logic [31:0]           r_redir_cnt;

  logic w_buf_valid, w_req_fire, w_load, w_pop;
  logic w_redir, w_misalign, w_redir_ok;

  assign w_redir     = redir_valid_i && (r_state != S_FAULT);
  assign w_misalign  = |(redir_pc_i[1:0] & INST_ALIGN_MASK);
  assign w_redir_ok  = w_redir && !w_misalign;

  // Gating on the raw redirect keeps a stale PC from ever being accepted.
  assign req_valid_o = (r_state == S_REQ) && !redir_valid_i && (!w_buf_valid || inst_ready_i);
  assign req_addr_o  = r_pc;
  assign w_req_fire  = req_valid_o && req_ready_i;
  assign w_load      = (r_state == S_WAIT) && rsp_valid_i && !redir_valid_i;
  assign w_pop       = w_buf_valid && inst_ready_i;

  fetch_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .INST_WIDTH(INST_WIDTH)
  ) u_buf (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .load_i     (w_load),
    .load_inst_i(rsp_data_i),
    .load_pc_i  (r_infl_pc),
    .pop_i      (w_pop),
    .flush_i    (w_redir),
    .valid_o    (w_buf_valid),
    .inst_o     (inst_o),
    .pc_o       (inst_pc_o)
  );

  assign inst_valid_o = w_buf_valid;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_REQ:   if (w_req_fire)  w_state_nxt = S_WAIT;
      S_WAIT:  if (rsp_valid_i) w_state_nxt = S_REQ;
      S_DRAIN: if (rsp_valid_i) w_state_nxt = S_REQ;
      default: w_state_nxt = S_FAULT;
    endcase
    if (w_redir) begin
      if (w_misalign) begin
        w_state_nxt = S_FAULT;
      end else if (r_state == S_WAIT || r_state == S_DRAIN) begin
        // A response arriving with the redirect is the stale one being squashed.
        w_state_nxt = rsp_valid_i ? S_REQ : S_DRAIN;
      end else begin
        w_state_nxt = S_REQ;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      r_state     <= S_REQ;
      r_pc        <= RESET_PC;
      r_infl_pc   <= '0;
      r_fault     <= 1'b0;
      r_fault_pc  <= '0;
      r_redir_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_redir_ok)      r_pc <= redir_pc_i;
      else if (w_req_fire) r_pc <= r_pc + PC_STEP;
      if (w_req_fire) r_infl_pc <= r_pc;
      if (w_redir && w_misalign) begin
        r_fault    <= 1'b1;
        r_fault_pc <= redir_pc_i;
      end
      if (w_redir_ok && (r_redir_cnt != 32'hFFFF_FFFF)) r_redir_cnt <= r_redir_cnt + 32'd1;
    end
  end

  assign fault_o     = r_fault;
  assign fault_pc_o  = r_fault_pc;
  assign redir_cnt_o = r_redir_cnt;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed table-driven bench for fetch_pc_ctrl with hand-written fault/saturation sequences.
module tb_fetch_pc_ctrl;

  localparam logic [63:0] A = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, rsp_valid, inst_valid, inst_ready;
  logic        redir_valid, fault;
  logic [63:0] req_addr, inst_pc, redir_pc, fault_pc;
  logic [31:0] rsp_data, inst, redir_cnt;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .req_valid_o  (req_valid),
    .req_addr_o   (req_addr),
    .req_ready_i  (req_ready),
    .rsp_valid_i  (rsp_valid),
    .rsp_data_i   (rsp_data),
    .inst_valid_o (inst_valid),
    .inst_o       (inst),
    .inst_pc_o    (inst_pc),
    .inst_ready_i (inst_ready),
    .redir_valid_i(redir_valid),
    .redir_pc_i   (redir_pc),
    .fault_o      (fault),
    .fault_pc_o   (fault_pc),
    .redir_cnt_o  (redir_cnt)
  );

  typedef struct {
    logic        rq;
    logic        rsv;
    logic [31:0] rsd;
    logic        ir;
    logic        rv;
    logic [63:0] rpc;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_iv;
    logic [31:0] e_inst;
    logic [63:0] e_ipc;
    logic        e_flt;
    logic [63:0] e_fpc;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic rq, logic rsv, logic [31:0] rsd, logic ir, logic rv,
                              logic [63:0] rpc, logic e_req, logic [63:0] e_addr, logic e_iv,
                              logic [31:0] e_inst, logic [63:0] e_ipc, logic e_flt,
                              logic [63:0] e_fpc, logic [31:0] e_cnt);
    vec_t v;
    v.rq = rq; v.rsv = rsv; v.rsd = rsd; v.ir = ir; v.rv = rv; v.rpc = rpc;
    v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
    v.e_flt = e_flt; v.e_fpc = e_fpc; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic chk(input string nm, input int row, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic rq, input logic rsv, input logic [31:0] rsd, input logic ir,
                       input logic rv, input logic [63:0] rpc);
    req_ready = rq; rsp_valid = rsv; rsp_data = rsd; inst_ready = ir;
    redir_valid = rv; redir_pc = rpc;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);

    //      rq rsv rsd       ir rv rpc                     req addr                  iv inst      ipc          flt fpc       cnt
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, A,                     0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(0, 1, 32'h11, 1, 0, 64'h0,              0, A+4,                   0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, A+4,                   1, 32'h11, A,           0, 64'h0, 0));
    vq.push_back(mk(0, 1, 32'h22, 1, 0, 64'h0,              0, A+8,                   0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  0, 0, 64'h0,              0, A+8,                   1, 32'h22, A+4,         0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  0, 0, 64'h0,              0, A+8,                   1, 32'h22, A+4,         0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, A+8,                   1, 32'h22, A+4,         0, 64'h0, 0));
    vq.push_back(mk(0, 1, 32'h33, 1, 0, 64'h0,              0, A+12,                  0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(0, 0, 32'h0,  1, 0, 64'h0,              1, A+12,                  1, 32'h33, A+8,         0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  0, 0, 64'h0,              1, A+12,                  0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(0, 0, 32'h0,  0, 1, A+64'h100,          0, A+16,                  0, 32'h0,  64'h0,       0, 64'h0, 0));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              0, A+64'h100,             0, 32'h0,  64'h0,       0, 64'h0, 1));
    vq.push_back(mk(1, 1, 32'h44, 1, 0, 64'h0,              0, A+64'h100,             0, 32'h0,  64'h0,       0, 64'h0, 1));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, A+64'h100,             0, 32'h0,  64'h0,       0, 64'h0, 1));
    vq.push_back(mk(0, 1, 32'h55, 1, 1, A+64'h200,          0, A+64'h104,             0, 32'h0,  64'h0,       0, 64'h0, 1));
    vq.push_back(mk(0, 0, 32'h0,  1, 0, 64'h0,              1, A+64'h200,             0, 32'h0,  64'h0,       0, 64'h0, 2));
    vq.push_back(mk(1, 0, 32'h0,  1, 1, A+64'h200,          0, A+64'h200,             0, 32'h0,  64'h0,       0, 64'h0, 2));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, A+64'h200,             0, 32'h0,  64'h0,       0, 64'h0, 3));
    vq.push_back(mk(0, 1, 32'h66, 1, 0, 64'h0,              0, A+64'h204,             0, 32'h0,  64'h0,       0, 64'h0, 3));
    vq.push_back(mk(1, 0, 32'h0,  1, 1, A+64'h300,          0, A+64'h204,             1, 32'h66, A+64'h200,   0, 64'h0, 3));
    vq.push_back(mk(0, 0, 32'h0,  0, 0, 64'h0,              1, A+64'h300,             0, 32'h0,  64'h0,       0, 64'h0, 4));
    vq.push_back(mk(0, 0, 32'h0,  0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 0, A+64'h300,        0, 32'h0,  64'h0,       0, 64'h0, 4));
    vq.push_back(mk(1, 0, 32'h0,  1, 0, 64'h0,              1, 64'hFFFF_FFFF_FFFF_FFFC, 0, 32'h0, 64'h0,      0, 64'h0, 5));
    vq.push_back(mk(0, 1, 32'h77, 1, 0, 64'h0,              0, 64'h0,                 0, 32'h0,  64'h0,       0, 64'h0, 5));
    vq.push_back(mk(0, 0, 32'h0,  0, 0, 64'h0,              0, 64'h0,                 1, 32'h77, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 5));
    vq.push_back(mk(0, 0, 32'h0,  1, 0, 64'h0,              1, 64'h0,                 1, 32'h77, 64'hFFFF_FFFF_FFFF_FFFC, 0, 64'h0, 5));
    vq.push_back(mk(1, 0, 32'h0,  1, 1, A+64'h102,          0, 64'h0,                 0, 32'h0,  64'h0,       0, 64'h0, 5));
    vq.push_back(mk(1, 1, 32'h88, 1, 0, 64'h0,              0, 64'h0,                 0, 32'h0,  64'h0,       1, A+64'h102, 5));
    vq.push_back(mk(1, 0, 32'h0,  1, 1, A+64'h400,          0, 64'h0,                 0, 32'h0,  64'h0,       1, A+64'h102, 5));
    vq.push_back(mk(1, 1, 32'h99, 1, 0, 64'h0,              0, 64'h0,                 0, 32'h0,  64'h0,       1, A+64'h102, 5));

    do_reset();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].rq, vq[i].rsv, vq[i].rsd, vq[i].ir, vq[i].rv, vq[i].rpc);
      #1;
      chk("req_valid", i, 64'(req_valid), 64'(vq[i].e_req));
      chk("req_addr", i, req_addr, vq[i].e_addr);
      chk("inst_valid", i, 64'(inst_valid), 64'(vq[i].e_iv));
      if (vq[i].e_iv || i == 0) begin
        chk("inst", i, 64'(inst), 64'(vq[i].e_inst));
        chk("inst_pc", i, inst_pc, vq[i].e_ipc);
      end
      chk("fault", i, 64'(fault), 64'(vq[i].e_flt));
      chk("fault_pc", i, fault_pc, vq[i].e_fpc);
      chk("redir_cnt", i, 64'(redir_cnt), 64'(vq[i].e_cnt));
      @(negedge clk);
    end

    // Reset out of the fault state clears the sticky fault.
    do_reset();
    #1;
    chk("rst_fault", 100, 64'(fault), 64'h0);
    chk("rst_fault_pc", 100, fault_pc, 64'h0);
    chk("rst_req_valid", 100, 64'(req_valid), 64'h1);
    chk("rst_req_addr", 100, req_addr, A);
    chk("rst_redir_cnt", 100, 64'(redir_cnt), 64'h0);

    // Redirect counter saturation, preset near the top.
    force dut.r_redir_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.r_redir_cnt;
    drive(0, 0, 0, 1, 1, A + 64'h10);
    #1;
    chk("sat_preset", 200, 64'(redir_cnt), 64'hFFFF_FFFE);
    @(negedge clk);
    #1;
    chk("sat_top", 201, 64'(redir_cnt), 64'hFFFF_FFFF);
    @(negedge clk);
    #1;
    chk("sat_hold", 202, 64'(redir_cnt), 64'hFFFF_FFFF);
    drive(0, 0, 0, 1, 0, 0);
    #1;
    chk("sat_addr", 203, req_addr, A + 64'h10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
